// File: rtl/fp_mac_pkg.sv
// Shared definitions for the floating-point MAC pipeline: controller state
// encoding and the default number of MAC register stages.
package fp_mac_pkg;

  localparam int PIPE_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_mac_valid_pipe.sv
// Token shift register mirroring the MAC step1..stepN stages; one cycle per stage,
// no backpressure, synchronous clear drops every in-flight token.
module fp_mac_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             in_vld,
  output logic [DEPTH-1:0] stage_valid
);

  logic [DEPTH-1:0] stage_valid_q;
  logic [DEPTH-1:0] stage_valid_d;

  always_comb begin
    stage_valid_d = {stage_valid_q[DEPTH-2:0], in_vld};
    if (clear) begin
      stage_valid_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stage_valid_q <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
    end
  end

  assign stage_valid = stage_valid_q;

endmodule

// File: rtl/fp_mac_seq_ctrl.sv
// Dot-product sequencer: one term in flight, issue -> write-back in PIPE_DEPTH cycles,
// in_ready held low until the previous term's write-back; result held until out_ready.
module fp_mac_seq_ctrl #(
  parameter int PIPE_DEPTH = fp_mac_pkg::PIPE_DEPTH,
  parameter int CNT_W      = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [CNT_W-1:0]      len,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  issue,
  output logic                  acc_clear,
  output logic [PIPE_DEPTH-1:0] stage_valid,
  output logic                  wb_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len
);

  import fp_mac_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;

  fp_mac_valid_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_valid_pipe (
    .clock       (clock),
    .resetn      (resetn),
    .clear       (abort),
    .in_vld      (issue),
    .stage_valid (stage_valid)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
    end
  end

  // remaining counts terms not yet issued, so it reads zero at the last write-back.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
      first_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (len != '0)) begin
            remaining_d = len;
            first_d     = 1'b1;
            state_d     = ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            first_d     = 1'b0;
            remaining_d = remaining_q - CNT_W'(1);
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (wb_en) begin
            state_d = (remaining_q == '0) ? HOLD : ISSUE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // abort masks every strobe in its own cycle so the datapath never acts on a dying job.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    err_len   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:    err_len = start & (len == '0) & ~abort;
      ISSUE:   in_ready = ~abort;
      WAIT:    ;
      HOLD: begin
        out_valid = 1'b1;
        done      = out_ready & ~abort;
      end
      default: ;
    endcase
    issue     = in_valid & in_ready;
    acc_clear = issue & first_q;
    wb_en     = stage_valid[PIPE_DEPTH-1] & (state_q == WAIT) & ~abort;
  end

endmodule
